// File: rtl/dqsw_train_ctrl.sv
// DQSW delay-line training: per lane, sweep taps upward until LATE goes 0->1 and record that tap.
// Build option DQSW_TRAIN_MAJORITY_EN: each tap decision is a 2-of-3 vote over three cleared LATE samples.

module dqsw_lane #(
   parameter int TAP_W = 7
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sel,
   input  logic             i_busy,
   input  logic             i_load,
   input  logic             i_move,
   input  logic             i_clear,
   input  logic             i_init,
   input  logic             i_set_res,
   input  logic             i_set_fail,
   input  logic [TAP_W-1:0] i_tap,
   output logic             o_load,
   output logic             o_move,
   output logic             o_dir,
   output logic             o_clear,
   output logic             o_fail,
   output logic [TAP_W-1:0] o_tap
);
   logic             r_fail;
   logic [TAP_W-1:0] r_tap;

   assign o_load  = i_sel & i_load;
   assign o_move  = i_sel & i_move;
   assign o_clear = i_sel & i_clear;
   assign o_dir   = i_sel & i_busy;
   assign o_fail  = r_fail;
   assign o_tap   = r_tap;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fail <= 1'b0;
         r_tap  <= '0;
      end else if (i_init) begin
         r_fail <= 1'b0;
         r_tap  <= '0;
      end else if (i_sel && i_set_fail) begin
         r_fail <= 1'b1;
         r_tap  <= '0;
      end else if (i_sel && i_set_res) begin
         r_tap  <= i_tap;
      end
   end
endmodule

module dqsw_train_ctrl #(
   parameter int  NUM_LANES     = 2,
   parameter int  MAX_TAPS      = 128,
   parameter int  SETTLE_CYCLES = 8,
   localparam int TAP_W         = $clog2(MAX_TAPS)
) (
   input  logic                       i_fab_clk,
   input  logic                       i_arst_n,
   input  logic                       i_start,
   input  logic [NUM_LANES-1:0]       i_eye_monitor_early,
   input  logic [NUM_LANES-1:0]       i_eye_monitor_late,
   input  logic [NUM_LANES-1:0]       i_delay_line_out_of_range,
   output logic [NUM_LANES-1:0]       o_delay_line_load,
   output logic [NUM_LANES-1:0]       o_delay_line_move,
   output logic [NUM_LANES-1:0]       o_delay_line_direction,
   output logic [NUM_LANES-1:0]       o_eye_monitor_clear_flags,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [NUM_LANES-1:0]       o_lane_fail,
   output logic [NUM_LANES*TAP_W-1:0] o_tap_result
);
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE, S_MOVE, S_NEXT_LANE, S_FINISH
   } state_t;

   state_t            r_state, w_next;
   logic [LANE_W-1:0] r_lane;
   logic [TAP_W-1:0]  r_tap;
   logic [7:0]        r_cnt;
   logic              r_seen_zero;
   logic w_init, w_load, w_clear, w_move, w_set_res, w_set_fail;
   logic w_smp_vld, w_smp, w_resample, w_busy, w_last, w_late, w_oor;
   logic w_unused;

   // EARLY is not part of the edge search; it is kept on the port for the IOD hookup.
   assign w_unused = ^i_eye_monitor_early;
   assign w_late   = i_eye_monitor_late[r_lane];
   assign w_oor    = i_delay_line_out_of_range[r_lane];
   assign w_last   = (r_lane == LANE_W'(NUM_LANES - 1));
   assign w_busy   = (r_state != S_IDLE) && (r_state != S_FINISH);
   assign o_busy   = w_busy;
   assign o_done   = (r_state == S_FINISH);

`ifdef DQSW_TRAIN_MAJORITY_EN
   logic [1:0] r_nsmp;
   logic [1:0] r_votes;
   logic       w_vote_tick;

   // Each vote is taken on the third SAMPLE cycle, i.e. after two idle cycles behind its CLEAR.
   assign w_vote_tick = (r_state == S_SAMPLE) && (r_cnt == 8'd2);
   assign w_smp_vld   = w_vote_tick && (r_nsmp == 2'd2);
   assign w_resample  = w_vote_tick && (r_nsmp != 2'd2);
   assign w_smp       = (r_votes[0] & r_votes[1]) | (r_votes[0] & w_late) | (r_votes[1] & w_late);

   always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_nsmp  <= '0;
         r_votes <= '0;
      end else if (w_init || w_load) begin
         r_nsmp  <= '0;
      end else if (w_resample) begin
         r_votes[r_nsmp[0]] <= w_late;
         r_nsmp             <= r_nsmp + 2'd1;
      end else if (w_smp_vld) begin
         r_nsmp  <= '0;
      end
   end
`else
   assign w_smp_vld  = (r_state == S_SAMPLE);
   assign w_resample = 1'b0;
   assign w_smp      = w_late;
`endif

   always_comb begin
      w_next     = r_state;
      w_init     = 1'b0;
      w_load     = 1'b0;
      w_clear    = 1'b0;
      w_move     = 1'b0;
      w_set_res  = 1'b0;
      w_set_fail = 1'b0;
      unique case (r_state)
         S_IDLE:   if (i_start) begin w_init = 1'b1; w_next = S_LOAD; end
         S_LOAD:   begin w_load = 1'b1; w_next = S_SETTLE; end
         S_SETTLE: if (r_cnt == 8'(SETTLE_CYCLES - 1)) w_next = S_CLEAR;
         S_CLEAR:  begin w_clear = 1'b1; w_next = S_SAMPLE; end
         S_SAMPLE: begin
            // LATE seen after a 0 is the edge; LATE before any 0 is an initial late region to skip.
            if (w_smp_vld) begin
               if (w_smp && r_seen_zero) begin
                  w_set_res = 1'b1;
                  w_next    = S_NEXT_LANE;
               end else begin
                  w_next    = S_MOVE;
               end
            end else if (w_resample) begin
               w_next = S_CLEAR;
            end
         end
         S_MOVE: begin
            if ((r_tap == TAP_W'(MAX_TAPS - 1)) || w_oor) begin
               w_set_fail = 1'b1;
               w_next     = S_NEXT_LANE;
            end else begin
               w_move = 1'b1;
               w_next = S_SETTLE;
            end
         end
         S_NEXT_LANE: w_next = w_last ? S_FINISH : S_LOAD;
         S_FINISH:    w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state     <= S_IDLE;
         r_lane      <= '0;
         r_tap       <= '0;
         r_cnt       <= '0;
         r_seen_zero <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= ((w_next != r_state) || (r_state == S_IDLE)) ? 8'd0 : r_cnt + 8'd1;
         if (w_init)
            r_lane <= '0;
         else if ((r_state == S_NEXT_LANE) && !w_last)
            r_lane <= r_lane + 1'b1;
         if (w_init || w_load)
            r_tap <= '0;
         else if (w_move)
            r_tap <= r_tap + 1'b1;
         if (w_init || w_load)
            r_seen_zero <= 1'b0;
         else if (w_smp_vld && !w_smp)
            r_seen_zero <= 1'b1;
      end
   end

   logic [NUM_LANES-1:0][TAP_W-1:0] w_tap_res;

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      dqsw_lane #(.TAP_W(TAP_W)) u_lane (
         .i_clk      (i_fab_clk),
         .i_rst_n    (i_arst_n),
         .i_sel      (r_lane == LANE_W'(gi)),
         .i_busy     (w_busy),
         .i_load     (w_load),
         .i_move     (w_move),
         .i_clear    (w_clear),
         .i_init     (w_init),
         .i_set_res  (w_set_res),
         .i_set_fail (w_set_fail),
         .i_tap      (r_tap),
         .o_load     (o_delay_line_load[gi]),
         .o_move     (o_delay_line_move[gi]),
         .o_dir      (o_delay_line_direction[gi]),
         .o_clear    (o_eye_monitor_clear_flags[gi]),
         .o_fail     (o_lane_fail[gi]),
         .o_tap      (w_tap_res[gi])
      );
   end

   assign o_tap_result = w_tap_res;
endmodule

// File: tb/tb_dqsw_train_ctrl.sv
// Directed bench for dqsw_train_ctrl: a behavioural delay-line/eye-monitor model per lane feeds LATE/OOR.
// Two instances: A (MAX_TAPS=64, SETTLE=3) and B (MAX_TAPS=16, SETTLE=1).

module tb_dqsw_train_ctrl;
   localparam int NEVER = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic stA, stB;
   logic [1:0] lateA, lateB, oorA, oorB;
   logic [1:0] earlyA, earlyB;
   logic [1:0] ldA, mvA, drA, clA, flA, ldB, mvB, drB, clB, flB;
   logic       bzA, dnA, bzB, dnB;
   logic [11:0] resA;
   logic [7:0]  resB;

   assign earlyA = 2'b00;
   assign earlyB = 2'b00;

   dqsw_train_ctrl #(.NUM_LANES(2), .MAX_TAPS(64), .SETTLE_CYCLES(3)) u_dut_a (
      .i_fab_clk(clk), .i_arst_n(rst_n), .i_start(stA),
      .i_eye_monitor_early(earlyA), .i_eye_monitor_late(lateA), .i_delay_line_out_of_range(oorA),
      .o_delay_line_load(ldA), .o_delay_line_move(mvA), .o_delay_line_direction(drA),
      .o_eye_monitor_clear_flags(clA), .o_busy(bzA), .o_done(dnA),
      .o_lane_fail(flA), .o_tap_result(resA));

   dqsw_train_ctrl #(.NUM_LANES(2), .MAX_TAPS(16), .SETTLE_CYCLES(1)) u_dut_b (
      .i_fab_clk(clk), .i_arst_n(rst_n), .i_start(stB),
      .i_eye_monitor_early(earlyB), .i_eye_monitor_late(lateB), .i_delay_line_out_of_range(oorB),
      .o_delay_line_load(ldB), .o_delay_line_move(mvB), .o_delay_line_direction(drB),
      .o_eye_monitor_clear_flags(clB), .o_busy(bzB), .o_done(dnB),
      .o_lane_fail(flB), .o_tap_result(resB));

   logic [1:0] ld[2], mv[2], cl[2], dr[2], fl[2], lt[2], oo[2];
   logic       bz[2], dn[2];
   int         res[2];
   assign ld[0] = ldA;  assign ld[1] = ldB;
   assign mv[0] = mvA;  assign mv[1] = mvB;
   assign cl[0] = clA;  assign cl[1] = clB;
   assign dr[0] = drA;  assign dr[1] = drB;
   assign fl[0] = flA;  assign fl[1] = flB;
   assign bz[0] = bzA;  assign bz[1] = bzB;
   assign dn[0] = dnA;  assign dn[1] = dnB;
   assign res[0] = 32'(resA);
   assign res[1] = 32'(resB);
   assign lateA = lt[0]; assign lateB = lt[1];
   assign oorA  = oo[0]; assign oorB  = oo[1];

   // Lane model: delay-line tap, clears since last tap change, pulse counters.
   int tap[2][2], clrc[2][2], mvc[2][2], ldc[2][2], dnc[2];
   int pre[2][2], edg[2][2], oat[2][2];
   bit glt[2][2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++)
            for (int l = 0; l < 2; l++) begin
               tap[d][l]  <= 0;
               clrc[d][l] <= 0;
            end
      end else begin
         for (int d = 0; d < 2; d++)
            for (int l = 0; l < 2; l++) begin
               if (ld[d][l]) begin
                  tap[d][l]  <= 0;
                  clrc[d][l] <= 0;
               end else if (mv[d][l] && dr[d][l]) begin
                  tap[d][l]  <= tap[d][l] + 1;
                  clrc[d][l] <= 0;
               end else if (cl[d][l]) begin
                  clrc[d][l] <= clrc[d][l] + 1;
               end
            end
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (dn[d]) dnc[d] <= dnc[d] + 1;
         for (int l = 0; l < 2; l++) begin
            if (mv[d][l]) mvc[d][l] <= mvc[d][l] + 1;
            if (ld[d][l]) ldc[d][l] <= ldc[d][l] + 1;
         end
      end
   end

   // LATE: 1 below pre, 0 up to edg, 1 from edg; glitch taps 3 and 6 read 1 only on the first sample.
   always_comb begin
      lt[0] = '0; lt[1] = '0; oo[0] = '0; oo[1] = '0;
      for (int d = 0; d < 2; d++)
         for (int l = 0; l < 2; l++) begin
            lt[d][l] = (tap[d][l] < pre[d][l]) || (tap[d][l] >= edg[d][l]) ||
                       (glt[d][l] && (tap[d][l] == 3 || tap[d][l] == 6) && clrc[d][l] == 1);
            oo[d][l] = (tap[d][l] >= oat[d][l]);
         end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic prof(input int d, input int l, input int p, input int e, input int o, input bit g);
      pre[d][l] = p; edg[d][l] = e; oat[d][l] = o; glt[d][l] = g;
   endtask

   task automatic set_start(input int d, input logic v);
      if (d == 0) stA = v;
      else        stB = v;
   endtask

   task automatic rst_zero(input int d);
      chk("rst_load",  32'(ld[d]), 0);
      chk("rst_move",  32'(mv[d]), 0);
      chk("rst_dir",   32'(dr[d]), 0);
      chk("rst_clear", 32'(cl[d]), 0);
      chk("rst_busy",  32'(bz[d]), 0);
      chk("rst_done",  32'(dn[d]), 0);
      chk("rst_fail",  32'(fl[d]), 0);
      chk("rst_res",   res[d], 0);
   endtask

   // Start a training run, optionally re-pulse START mid-run, wait for DONE within a budget.
   task automatic run(input int d, input int budget, input int restart_at);
      int c;
      int d0;
      d0 = dnc[d];
      @(negedge clk); set_start(d, 1'b1);
      @(negedge clk); set_start(d, 1'b0);
      chk("busy_go", 32'(bz[d]), 1);
      chk("dir_lane0", 32'(dr[d]), 1);
      c = 0;
      while (!dn[d] && c < budget) begin
         @(negedge clk);
         c++;
         set_start(d, c == restart_at);
      end
      set_start(d, 1'b0);
      chk("done_seen", 32'(dn[d]), 1);
      chk("busy_at_done", 32'(bz[d]), 0);
      @(negedge clk);
      chk("done_once", dnc[d] - d0, 1);
   endtask

   int m0, m1, l0, l1, c, d0;

   initial begin
      rst_n = 1'b0; stA = 1'b0; stB = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int l = 0; l < 2; l++) prof(d, l, 0, NEVER, NEVER, 1'b0);
      repeat (3) @(negedge clk);
      rst_zero(0);
      rst_zero(1);
      rst_n = 1'b1;
      @(negedge clk);

      // lane0 edge 10, lane1 edge 40; a START mid-run must be dropped
      prof(0, 0, 0, 10, NEVER, 1'b0);
      prof(0, 1, 0, 40, NEVER, 1'b0);
      m0 = mvc[0][0]; m1 = mvc[0][1]; l0 = ldc[0][0]; l1 = ldc[0][1];
      run(0, 4000, 20);
      chk("t1_res", res[0], 40*64 + 10);
      chk("t1_fail", 32'(fl[0]), 0);
      chk("t1_mv0", mvc[0][0] - m0, 10);
      chk("t1_mv1", mvc[0][1] - m1, 40);
      chk("t1_ld0", ldc[0][0] - l0, 1);
      chk("t1_ld1", ldc[0][1] - l1, 1);
      repeat (10) @(negedge clk);
      chk("t1_hold", res[0], 40*64 + 10);
      chk("t1_idle_dir", 32'(dr[0]), 0);

      // initial late region taps 0..4 skipped
      prof(0, 0, 5, 20, NEVER, 1'b0);
      run(0, 4000, -1);
      chk("t2_res", res[0], 40*64 + 20);
      chk("t2_fail", 32'(fl[0]), 0);

      // lane0 out-of-range from tap 7, lane1 still trained
      prof(0, 0, 0, NEVER, 7, 1'b0);
      prof(0, 1, 0, 12, NEVER, 1'b0);
      m0 = mvc[0][0];
      run(0, 4000, -1);
      chk("t3_res", res[0], 12*64);
      chk("t3_fail", 32'(fl[0]), 1);
      chk("t3_mv0", mvc[0][0] - m0, 7);

      // reset at tap 5 of lane0 aborts without DONE
      prof(0, 0, 0, 10, NEVER, 1'b0);
      prof(0, 1, 0, 40, NEVER, 1'b0);
      @(negedge clk); stA = 1'b1;
      @(negedge clk); stA = 1'b0;
      c = 0;
      while (tap[0][0] != 5 && c < 2000) begin @(negedge clk); c++; end
      chk("t4_reach5", tap[0][0], 5);
      d0 = dnc[0];
      rst_n = 1'b0;
      #1;
      rst_zero(0);
      repeat (3) @(negedge clk);
      chk("t4_nodone", dnc[0] - d0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run(0, 4000, -1);
      chk("t4_res", res[0], 40*64 + 10);
      chk("t4_fail", 32'(fl[0]), 0);

      // single-sample LATE glitches at taps 3 and 6
      prof(0, 0, 0, 10, NEVER, 1'b1);
      run(0, 4000, -1);
`ifdef DQSW_TRAIN_MAJORITY_EN
      chk("t5_res", res[0], 40*64 + 10);
`else
      chk("t5_res", res[0], 40*64 + 3);
`endif
      prof(0, 0, 0, 10, NEVER, 1'b0);

      // instance B: lane1 stuck 0 runs out of taps
      prof(1, 0, 0, 5, NEVER, 1'b0);
      prof(1, 1, 0, NEVER, NEVER, 1'b0);
      m1 = mvc[1][1]; l1 = ldc[1][1];
      run(1, 4000, -1);
      chk("t6_res", res[1], 5);
      chk("t6_fail", 32'(fl[1]), 2);
      chk("t6_mv1", mvc[1][1] - m1, 15);
      chk("t6_ld1", ldc[1][1] - l1, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/dqsw_train_ctrl.md
DQSW_TRAIN_CTRL -- requirements
Module: dqsw_train_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 2, sets the number of DQSW lanes trained sequentially, legal range 1..8.
REQ-002 Parameter MAX_TAPS, default 128, sets the delay-line tap count per lane; TAP_W = clog2(MAX_TAPS).
REQ-003 Parameter SETTLE_CYCLES, default 8, sets the wait in FAB_CLK cycles after any delay-line change before sampling, legal range 1..255.
REQ-004 FAB_CLK  in  1  sole clock; all logic on the rising edge.
REQ-005 ARST_N  in  1  reset; asynchronous assert, active-low.
REQ-006 START  in  1  one-cycle request to begin training; ignored while BUSY=1.
REQ-007 EYE_MONITOR_EARLY  in  NUM_LANES  per-lane early flag from the IOD.
REQ-008 EYE_MONITOR_LATE  in  NUM_LANES  per-lane late flag from the IOD.
REQ-009 DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane delay-line saturation flag.
REQ-010 DELAY_LINE_LOAD  out  NUM_LANES  one-cycle pulse that reloads the lane delay line to tap 0.
REQ-011 DELAY_LINE_MOVE  out  NUM_LANES  one-cycle pulse that steps the lane delay line by one tap.
REQ-012 DELAY_LINE_DIRECTION  out  NUM_LANES  step direction; held at 1 (increment) for the active lane, otherwise 0.
REQ-013 EYE_MONITOR_CLEAR_FLAGS  out  NUM_LANES  one-cycle pulse that clears the lane eye-monitor flags.
REQ-014 BUSY  out  1  high from the cycle after START is accepted until DONE asserts.
REQ-015 DONE  out  1  one-cycle pulse when all lanes have finished.
REQ-016 LANE_FAIL  out  NUM_LANES  sticky per-lane failure flags, valid when DONE pulses.
REQ-017 TAP_RESULT  out  NUM_LANES*TAP_W  trained tap per lane; lane i occupies bits [i*TAP_W +: TAP_W].

Function
REQ-018 FSM states: IDLE, LOAD, SETTLE, CLEAR, SAMPLE, MOVE, NEXT_LANE, FINISH; exactly one lane, indexed by lane_idx, is active at a time.
REQ-019 IDLE->LOAD on START=1; this clears lane_idx, LANE_FAIL, TAP_RESULT, the tap counter and seen_zero.
REQ-020 LOAD drives DELAY_LINE_LOAD[lane_idx] for 1 cycle, resets tap to 0, then goes to SETTLE.
REQ-021 SETTLE counts SETTLE_CYCLES cycles, then goes to CLEAR.
REQ-022 CLEAR drives EYE_MONITOR_CLEAR_FLAGS[lane_idx] for 1 cycle, then goes to SAMPLE.
REQ-023 SAMPLE registers the active lane's LATE value as the sample (see REQ-033 for the alternative).
REQ-024 In SAMPLE, if sample=0: set seen_zero and go to MOVE.
REQ-025 In SAMPLE, if sample=1 and seen_zero=1: the edge is found; TAP_RESULT[lane_idx] takes the tap value and the FSM goes to NEXT_LANE.
REQ-026 In SAMPLE, if sample=1 and seen_zero=0: go to MOVE (skips an initial late region).
REQ-027 MOVE with tap=MAX_TAPS-1, or with DELAY_LINE_OUT_OF_RANGE[lane_idx]=1: set LANE_FAIL[lane_idx], set TAP_RESULT[lane_idx] to 0, go to NEXT_LANE, and do not pulse MOVE.
REQ-028 MOVE otherwise: pulse DELAY_LINE_MOVE[lane_idx] for 1 cycle, increment tap, go to SETTLE.
REQ-029 NEXT_LANE: if lane_idx=NUM_LANES-1 go to FINISH; otherwise increment lane_idx and go to LOAD.
REQ-030 FINISH pulses DONE for 1 cycle, deasserts BUSY in the same cycle, and returns to IDLE; results hold until the next accepted START.
REQ-031 All control outputs for non-active lanes stay 0; a START arriving during BUSY is dropped and has no other effect.

Reset
REQ-032 With ARST_N=0: FSM=IDLE; all outputs, counters, seen_zero, LANE_FAIL and TAP_RESULT are 0. Reset mid-training aborts immediately with no DONE pulse.

Configuration
REQ-033 Macro DQSW_TRAIN_MAJORITY_EN selects the sampling mode.
- When defined: SAMPLE takes three LATE samples, each preceded by its own CLEAR plus 2 idle cycles, and the sample is their 2-of-3 majority.
- When undefined: single sample as in REQ-023.
- All other behaviour is identical in both modes.

Verification
REQ-034 NUM_LANES=2, lane0 LATE=0 for taps 0..9 and 1 from tap 10, lane1 edge at tap 40 -> TAP_RESULT={40,10}, LANE_FAIL=00, DONE pulses once.
REQ-035 Lane0 LATE=1 at taps 0..4, 0 at taps 5..19, 1 from tap 20 -> TAP_RESULT[0]=20.
REQ-036 Lane1 LATE stuck 0 with MAX_TAPS=16 -> LANE_FAIL=10, TAP_RESULT[1]=0, exactly 15 MOVE pulses on lane1.
REQ-037 OUT_OF_RANGE[0] asserted at tap 7 -> LANE_FAIL[0]=1 and lane1 is still trained.
REQ-038 ARST_N pulsed low at tap 5 of lane0 -> all outputs 0 and no DONE; a subsequent START trains normally.
REQ-039 With DQSW_TRAIN_MAJORITY_EN defined and single-sample LATE glitches (1 of 3) at taps 3 and 6 -> edge found only at the true tap 10.
